// File: rtl/sram_pkg.sv
// Shared defaults and state type for the SRAM read-side controller.
package sram_pkg;
  localparam int unsigned SRAM_DATA_WIDTH = 32;
  localparam int unsigned SRAM_ADDR_WIDTH = 11;
  localparam int unsigned SRAM_LEN_WIDTH  = 4;
  localparam int unsigned SRAM_FIFO_DEPTH = 4;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_t;
endpackage

// File: rtl/sram_rd_fifo.sv
// Synchronous show-ahead response FIFO; outputs zero data while empty.
module sram_rd_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push && (!full || pop);
  // A pop while empty only takes effect against a same-cycle push.
  assign do_pop  = pop && (!empty || push);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_ONE;
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
  assign count    = count_q;
endmodule

// File: rtl/sram_rd_ctrl.sv
// Read-side controller for SRAM port 1 with credit-limited response FIFO.
// Burst requests (req_len honoured) are enabled by defining SRAM_RD_BURST_EN.
module sram_rd_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = SRAM_FIFO_DEPTH,
  parameter int unsigned LEN_WIDTH  = SRAM_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  csb1,
  output logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] dout1,
  output logic                  busy
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_t             state_q, state_d;
  logic                  csb1_q;
  logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
  logic [1:0]            inflight_q;
  logic                  issue;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_empty;
  logic [CW:0]           occupancy;
  logic                  credit;

`ifdef SRAM_RD_BURST_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
  logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
`else
  logic unused_len;
  assign unused_len = ^req_len;
`endif

  // Credit is taken from registered state only, so a same-cycle pop does not free a slot early.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q[0]) + (CW+1)'(inflight_q[1]);
  assign credit    = !rst && (occupancy < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    state_d   = state_q;
    addr1_d   = addr1_q;
    issue     = 1'b0;
    req_ready = 1'b0;
`ifdef SRAM_RD_BURST_EN
    baddr_d   = baddr_q;
    remain_d  = remain_q;
`endif
    case (state_q)
      RD_IDLE: begin
        req_ready = credit;
        if (req_valid && credit) begin
          issue   = 1'b1;
          addr1_d = req_addr;
`ifdef SRAM_RD_BURST_EN
          if (req_len != '0) begin
            state_d  = RD_BURST;
            baddr_d  = req_addr + ADDR_ONE;
            remain_d = req_len;
          end
`endif
        end
      end
      RD_BURST: begin
`ifdef SRAM_RD_BURST_EN
        if (credit) begin
          issue    = 1'b1;
          addr1_d  = baddr_q;
          baddr_d  = baddr_q + ADDR_ONE;
          remain_d = remain_q - LEN_ONE;
          if (remain_q == LEN_ONE) state_d = RD_IDLE;
        end
`else
        state_d = RD_IDLE;
`endif
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      csb1_q     <= 1'b1;
      addr1_q    <= '0;
      inflight_q <= '0;
`ifdef SRAM_RD_BURST_EN
      baddr_q    <= '0;
      remain_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      csb1_q     <= !issue;
      addr1_q    <= addr1_d;
      inflight_q <= {inflight_q[0], issue};
`ifdef SRAM_RD_BURST_EN
      baddr_q    <= baddr_d;
      remain_q   <= remain_d;
`endif
    end
  end

  sram_rd_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q[1]),
    .push_data (dout1),
    .pop       (rsp_valid && rsp_ready),
    .pop_data  (rsp_data),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign csb1      = csb1_q;
  assign addr1     = addr1_q;
  assign busy      = (state_q == RD_BURST) || (|inflight_q) || !fifo_empty;
endmodule

// File: tb/tb_sram_rd_ctrl.sv
// Directed bench for sram_rd_ctrl: SRAM timing model, queue-based expectations, per-cycle checker.
module tb_sram_rd_ctrl;
  localparam int DEPTH = 4;

`ifdef SRAM_RD_BURST_EN
  localparam int T4_WORDS = 4;
  localparam int T6_WORDS = 6;
`else
  localparam int T4_WORDS = 1;
  localparam int T6_WORDS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [10:0] req_addr = '0;
  logic [3:0]  req_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        csb1;
  logic [10:0] addr1;
  logic [31:0] dout1 = '0;
  logic        busy;

  sram_rd_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .csb1      (csb1),
    .addr1     (addr1),
    .dout1     (dout1),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // SRAM model: registered inputs, data driven on the following negedge.
  logic [31:0] mem [2048];
  logic        sram_en = 1'b0;
  logic [10:0] sram_addr = '0;
  initial for (int i = 0; i < 2048; i++) mem[i] = i * 32'h0101_0101;
  always @(posedge clk) begin
    sram_en   <= !csb1;
    sram_addr <= addr1;
  end
  always @(negedge clk) if (sram_en) dout1 <= mem[sram_addr];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int pops = 0;
  int outstanding = 0;
  logic [10:0] exp_issue[$];
  logic [31:0] exp_data[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] word_of(input int a);
    return 32'(a) * 32'h0101_0101;
  endfunction

  // Reference model: every accepted request expands into its word addresses; issues and
  // responses must follow that order, and issued-but-unconsumed words never exceed the FIFO depth.
  always @(negedge clk) begin
    if (rst) begin
      exp_issue.delete();
      exp_data.delete();
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      if (!csb1) begin
        if (exp_issue.size() == 0) fail_now("spurious_issue");
        else check("issue_addr", 32'(addr1), 32'(exp_issue.pop_front()));
        outstanding++;
      end
      check("credit_limit", 32'(outstanding <= DEPTH), 32'd1);
      if (prev_stall) begin
        check("stall_valid", 32'(rsp_valid), 32'd1);
        check("stall_data", rsp_data, prev_data);
      end
      prev_stall = 1'b0;
      if (rsp_valid && exp_data.size() == 0) fail_now("stale_rsp");
      else if (rsp_valid && rsp_ready) begin
        check("rsp_data", rsp_data, exp_data.pop_front());
        outstanding--;
        pops++;
      end else if (rsp_valid) begin
        prev_stall = 1'b1;
        prev_data  = rsp_data;
      end
      if (req_valid && req_ready) begin
        int n;
`ifdef SRAM_RD_BURST_EN
        n = int'(req_len) + 1;
`else
        n = 1;
`endif
        for (int i = 0; i < n; i++) begin
          exp_issue.push_back(11'((int'(req_addr) + i) % 2048));
          exp_data.push_back(word_of((int'(req_addr) + i) % 2048));
        end
      end
    end
  end

  // Presents one request; returns #1 after the accepting posedge.
  task automatic send(input logic [10:0] a, input logic [3:0] l);
    int t;
    logic acc;
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
    t = 0;
    acc = 1'b0;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) fail_now("req_accept_timeout");
  endtask

  task automatic idle();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (busy) fail_now("drain_timeout");
    check("drain_issue_q", 32'(exp_issue.size()), 32'd0);
    check("drain_data_q", 32'(exp_data.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic single_read_0x005();
    send(11'h005, 4'd0);
    idle();
    check("t1_csb1", 32'(csb1), 32'd0);
    check("t1_addr1", 32'(addr1), 32'h005);
    @(posedge clk); #1;
    check("t1_valid_k1", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("t1_valid_k2", 32'(rsp_valid), 32'd1);
    check("t1_data_k2", rsp_data, 32'h0505_0505);
    drain();
  endtask

  initial begin
    int c0, p0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_csb1", 32'(csb1), 32'd1);
    check("rst_addr1", 32'(addr1), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // 1: single read latency
    rsp_ready = 1'b1;
    single_read_0x005();

    // 2: back-to-back singles, one accepted per cycle
    send(11'h010, 4'd0);
    c0 = cyc;
    send(11'h011, 4'd0);
    send(11'h012, 4'd0);
    idle();
    check("t2_b2b_cycles", 32'(cyc - c0), 32'd2);
    drain();

    // 3: backpressure caps issue at FIFO depth
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(11'h020 + 11'(i), 4'd0);
    req_valid = 1'b1;
    req_addr  = 11'h024;
    req_len   = 4'd0;
    @(negedge clk);
    check("t3_ready_full", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_ready_hold", 32'(req_ready), 32'd0);
      check("t3_csb1_hold", 32'(csb1), 32'd1);
    end
    check("t3_head_data", rsp_data, 32'h2020_2020);
    check("t3_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(11'h024, 4'd0);
    idle();
    drain();

    // 4: burst across the address wrap
    p0 = pops;
    send(11'h7FE, 4'd3);
    idle();
    drain();
    check("t4_word_count", 32'(pops - p0), 32'(T4_WORDS));
    send(11'h7FF, 4'd0);
    send(11'h000, 4'd0);
    idle();
    drain();

    // burst (or single) stalled by backpressure, then released
    rsp_ready = 1'b0;
    send(11'h300, 4'd7);
    idle();
    repeat (10) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain();

    // 6: req_len honoured only with bursts enabled
    p0 = pops;
    send(11'h040, 4'd5);
    idle();
    drain();
    check("t6_word_count", 32'(pops - p0), 32'(T6_WORDS));

    // 5: reset with two reads in flight
    send(11'h100, 4'd7);
`ifdef SRAM_RD_BURST_EN
    idle();
    @(posedge clk); #1;
`else
    send(11'h101, 4'd0);
    idle();
`endif
    check("t5_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_csb1", 32'(csb1), 32'd1);
    check("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_rsp_data", rsp_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("t5_no_stale", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    single_read_0x005();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
    $fatal(1, "watchdog expired");
  end
endmodule
